bcd_converter: RTL and testbench
================================

BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as stated below.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 clr_n  input  1  reset; the block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-004 bin  input  32  unsigned binary value to convert (CPU display word).
REQ-005 start  input  1  conversion request; sampled on the rising clock edge.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse marking that a new result is valid.
REQ-008 bcd  output  32  8 packed BCD digits; digit 0 = bcd[3:0], digit 7 = bcd[31:28]; feeds seg_display datas.
REQ-009 overflow  output  1  high when the last converted value exceeded 99,999,999.

Function
REQ-010 The state machine SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-011 In IDLE with start=1 at an edge, the block SHALL:
- latch bin into a 32-bit shift register;
- clear a 40-bit (10-digit) BCD scratch register and a 5-bit shift counter;
- enter SHIFT.
REQ-012 In SHIFT, each cycle SHALL:
- add 3 to every scratch digit >= 5;
- shift {scratch, shift register} left by one;
- increment the counter.
REQ-013 SHIFT SHALL last exactly 32 cycles; after the 32nd shift the state SHALL be DONE.
REQ-014 On the edge leaving DONE, the block SHALL register bcd and overflow; done SHALL be 1 for exactly that one following cycle; state SHALL return to IDLE.
REQ-015 Latency: with start sampled at edge N, done SHALL be high between edges N+33 and N+34, and bcd/overflow SHALL be valid from edge N+33.
REQ-016 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-017 start in SHIFT or DONE SHALL be ignored (not queued); bin changes after the sampling edge SHALL NOT affect the result.
REQ-018 start asserted continuously SHALL restart a conversion on the first IDLE edge, giving a back-to-back period of 34 cycles.
REQ-019 overflow SHALL be 1 iff scratch digits 9..8 are nonzero at completion.
REQ-020 bcd and overflow SHALL hold their values until the next completion; in particular they SHALL hold during SHIFT.
REQ-021 The maximum input 0xFFFFFFFF (4,294,967,295) SHALL convert without internal wrap.

Reset
REQ-022 When clr_n=0 at an edge, the block SHALL set: state=IDLE, busy=0, done=0, bcd=0x00000000, overflow=0, counter=0, scratch=0.
REQ-023 Reset SHALL take priority over start and abort any conversion in progress with no done pulse.
REQ-024 A start sampled on the first edge with clr_n=1 SHALL be accepted.

Configuration
REQ-025 The macro BCD_OVERFLOW_SAT_EN SHALL select the overflow behaviour of bcd.
- Defined: on overflow, bcd SHALL saturate to 0x99999999.
- Undefined: bcd SHALL be the low 8 scratch digits (truncated).
REQ-026 overflow SHALL behave identically in both configurations.

Verification
REQ-027 Reset, then bin=0, start pulse -> busy 1 for 33 cycles, then done pulse; bcd=0x00000000, overflow=0.
REQ-028 bin=12345678 (decimal), start -> bcd=0x12345678 exactly 33 cycles after start; then bin=99999999 -> bcd=0x99999999, overflow=0.
REQ-029 bin=100000000 -> overflow=1; bcd=0x99999999 with BCD_OVERFLOW_SAT_EN, 0x00000000 without; bin=0xFFFFFFFF -> overflow=1; bcd=0x99999999 with the macro, 0x94967295 without.
REQ-030 Start with bin=42, then bin=7 and start pulsed at cycle 10 -> single done pulse; bcd=0x00000042; no second conversion.
REQ-031 clr_n=0 at cycle 20 of a conversion -> next cycle busy=0, bcd=0, no done pulse; a new start converts correctly.
REQ-032 start held high with bin=5 -> done pulses every 34 cycles; bcd=0x00000005 throughout.

Source files
------------

// File: rtl/bcd_converter.sv
// Sequential double-dabble converter: 32-bit binary to 8 packed BCD digits plus overflow.
// Build with BCD_OVERFLOW_SAT_EN defined to saturate bcd to 0x99999999 on overflow.
module bcd_converter (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] bin,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd,
  output logic        overflow,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] shift_reg;
  logic [39:0] scratch;
  logic [4:0]  count;
  logic [39:0] adjusted;
  logic        scratch_ovf;
  logic [31:0] bcd_next;

  // Handshake: start is sampled only in IDLE; busy covers SHIFT and DONE;
  // done is a one-cycle pulse and bcd/overflow are valid from that cycle on.
  assign state_dbg = state;

  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < 10; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  assign scratch_ovf = |scratch[39:32];

`ifdef BCD_OVERFLOW_SAT_EN
  assign bcd_next = scratch_ovf ? 32'h9999_9999 : scratch[31:0];
`else
  assign bcd_next = scratch[31:0];
`endif

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= 32'h0;
      overflow  <= 1'b0;
      count     <= 5'd0;
      scratch   <= 40'h0;
      shift_reg <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            scratch   <= 40'h0;
            count     <= 5'd0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjust-then-shift: the MSB of the binary word enters the BCD LSB.
          scratch   <= {adjusted[38:0], shift_reg[31]};
          shift_reg <= {shift_reg[30:0], 1'b0};
          count     <= count + 5'd1;
          if (count == 5'd31) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd      <= bcd_next;
          overflow <= scratch_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter: directed scenarios plus random values
// checked against a decimal-arithmetic reference model.
module tb_bcd_converter;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [31:0] bin = 32'h0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        overflow;
  logic [1:0]  state_dbg;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  logic [31:0] prev_bcd = 32'h0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_converter dut (
    .clk(clk), .clr_n(clr_n), .bin(bin), .start(start),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow),
    .state_dbg(state_dbg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_bcd(input logic [31:0] v);
    longint unsigned x;
    logic [31:0] r;
    x = longint'(v);
    r = 32'h0;
`ifdef BCD_OVERFLOW_SAT_EN
    if (x > 64'd99999999) return 32'h9999_9999;
`endif
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input logic [31:0] v);
    return longint'(v) > 64'd99999999;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion of v; optionally pulse start with poke_val at cycle poke.
  task automatic conv(input string tag, input logic [31:0] v, input int poke,
                      input logic [31:0] poke_val);
    int lat;
    int busy_bad;
    int hold_bad;
    int done_bad;
    logic [31:0] eb;
    exp_q.push_back(model_bcd(v));
    lat = 0; busy_bad = 0; hold_bad = 0; done_bad = 0;
    bin = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin = $urandom;
    if (busy !== 1'b1) busy_bad++;
    while (lat < 40) begin
      if (lat == poke) begin
        start = 1'b1;
        bin = poke_val;
      end
      tick();
      start = 1'b0;
      bin = $urandom;
      lat++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_bad++;
      if (bcd !== prev_bcd) hold_bad++;
    end
    eb = exp_q.pop_front();
    check({tag, " latency"}, 32'(lat), 32'd33);
    check({tag, " busy_during"}, 32'(busy_bad), 32'd0);
    check({tag, " bcd_hold"}, 32'(hold_bad), 32'd0);
    check({tag, " bcd"}, bcd, eb);
    check({tag, " overflow"}, {31'b0, overflow}, {31'b0, model_ovf(v)});
    check({tag, " busy_end"}, {31'b0, busy}, 32'd0);
    prev_bcd = eb;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || bcd !== eb) done_bad++;
    end
    check({tag, " idle_after"}, 32'(done_bad), 32'd0);
  endtask

  initial begin
    int lat;
    int bad;
    logic [31:0] v;

    // Reset state
    clr_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst bcd", bcd, 32'h0);
    check("rst overflow", {31'b0, overflow}, 32'd0);
    start = 1'b0;
    clr_n = 1'b1;

    // First edge with clr_n high accepts start
    conv("zero", 32'd0, -1, 32'd0);
    conv("dec12345678", 32'd12345678, -1, 32'd0);
    conv("dec99999999", 32'd99999999, -1, 32'd0);
    conv("dec100000000", 32'd100000000, -1, 32'd0);
    conv("max", 32'hFFFF_FFFF, -1, 32'd0);
    conv("ignored_start", 32'd42, 10, 32'd7);

    // Abort at cycle 20 of a conversion
    bin = 32'd777;
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done !== 1'b0) bad++;
    end
    clr_n = 1'b0;
    tick();
    check("abort no_done", 32'(bad) + {31'b0, done}, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort bcd", bcd, 32'h0);
    check("abort overflow", {31'b0, overflow}, 32'd0);
    prev_bcd = 32'h0;
    clr_n = 1'b1;
    conv("after_abort", 32'd31415926, -1, 32'd0);

    // start held high: back-to-back conversions every 34 cycles
    bin = 32'd5;
    start = 1'b1;
    lat = 0;
    while (lat < 80 && done !== 1'b1) begin
      tick();
      lat++;
    end
    check("b2b first_done", {31'b0, done}, 32'd1);
    for (int p = 0; p < 3; p++) begin
      lat = 0;
      bad = 0;
      do begin
        tick();
        lat++;
        if (bcd !== 32'h5) bad++;
      end while (lat < 80 && done !== 1'b1);
      if (p == 2) start = 1'b0;
      check("b2b period", 32'(lat), 32'd34);
      check("b2b bcd", bcd + 32'(bad), 32'h5);
    end
    prev_bcd = 32'h5;
    tick();
    tick();
    check("b2b stop", {31'b0, busy}, 32'd0);

    // Randomized values
    for (int r = 0; r < 16; r++) begin
      if (r % 2 == 0) v = $urandom_range(0, 99999999);
      else v = $urandom;
      conv("rand", v, (r % 4 == 3) ? int'($urandom_range(1, 32)) : -1, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
